// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I data port: word RAM, byte-masked writes,
// WAIT_CYCLES wait states, one-cycle valid pulse. `DMEM_RANGE_CHK_EN adds an err output.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDRESS     = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  request,
  input  logic                  we_re,
  input  logic [3:0]            mask,
  input  logic [ADDRESS-1:0]    address,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  valid
`ifdef DMEM_RANGE_CHK_EN
  ,
  output logic                  err
`endif
);

  localparam int IW    = $clog2(DEPTH);
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [3:0]              mask_q;
  logic [ADDRESS-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   load_data_q;
  logic                    valid_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // With zero wait states the access happens on the same edge the request is
  // latched, so the live inputs are used while in IDLE.
  logic                    t_we;
  logic [3:0]              t_mask;
  logic [ADDRESS-1:0]      t_addr;
  logic [DATA_WIDTH-1:0]   t_wdata;
  logic [IW-1:0]           idx;
  logic                    access;
  logic                    oor;

  always_comb begin
    t_we    = we_q;
    t_mask  = mask_q;
    t_addr  = addr_q;
    t_wdata = wdata_q;
    if (state_q == IDLE) begin
      t_we    = we_re;
      t_mask  = mask;
      t_addr  = address;
      t_wdata = store_data;
    end
  end

  assign idx    = t_addr[IW+1:2];
  assign access = (state_d == RESP) && (state_q != RESP);

`ifdef DMEM_RANGE_CHK_EN
  logic       err_q;
  logic [1:0] unused_addr_bits;
  assign oor              = (t_addr >> (IW + 2)) != '0;
  assign unused_addr_bits = t_addr[1:0];
  assign err              = err_q;
`else
  logic unused_addr_bits;
  assign oor              = 1'b0;
  assign unused_addr_bits = ^{t_addr[1:0], t_addr[ADDRESS-1:IW+2]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      mask_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= access;
      if (state_q == IDLE && request) begin
        we_q    <= we_re;
        mask_q  <= mask;
        addr_q  <= address;
        wdata_q <= store_data;
      end
      if (access && !t_we) load_data_q <= oor ? '0 : mem[idx];
    end
  end

`ifdef DMEM_RANGE_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= access && oor;
  end
`endif

  // RAM has no reset; rst gating keeps a reset-aborted write from landing.
  always_ff @(posedge clk) begin
    if (!rst && access && t_we && !oor) begin
      for (int i = 0; i < LANES; i++) begin
        if (t_mask[i]) mem[idx][8*i +: 8] <= t_wdata[8*i +: 8];
      end
    end
  end

  assign load_data = load_data_q;
  assign valid     = valid_q;

endmodule
